// File: rtl/rr_arb_pkg.sv
// Shared types and the rotating-priority pick function
// for the round-robin one-hot arbiter.
package rr_arb_pkg;

    localparam int unsigned RR_MAX_BITS = 8;
    localparam int unsigned RR_MAX_N    = 1 << RR_MAX_BITS;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } arb_state_t;

    typedef struct packed {
        logic        found;
        logic [31:0] idx;
    } rr_pick_t;

    // First set request at or after ptr, wrapping modulo n (n is a power of two).
    // Scans from the farthest offset down so the nearest hit is written last.
    function automatic rr_pick_t rr_pick(
        input logic [RR_MAX_N-1:0] req,
        input logic [31:0]         ptr,
        input logic [31:0]         n
    );
        rr_pick_t    r;
        logic [31:0] k;
        r.found = 1'b0;
        r.idx   = '0;
        for (int i = RR_MAX_N - 1; i >= 0; i--) begin
            k = (ptr + 32'(i)) & (n - 32'd1);
            if ((32'(i) < n) && req[k[RR_MAX_BITS-1:0]]) begin
                r.found = 1'b1;
                r.idx   = k;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_onehot_dec.sv
// Binary index to one-hot vector decoder.
// Used on the next-state grant index of the arbiter.
module rr_onehot_dec #(
    parameter int BITS = 3
) (
    input  logic [BITS-1:0]      a,
    output logic [(1<<BITS)-1:0] y
);

    // Set exactly the bit addressed by a.
    always_comb begin
        y    = '0;
        y[a] = 1'b1;
    end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with hold timeout and one-hot registered grant.
// Optional owner lock port enabled by defining ARB_LOCK_EN.
module rr_onehot_arbiter
    import rr_arb_pkg::*;
#(
    parameter int BITS     = 3,
    parameter int MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [(1<<BITS)-1:0] req,
    input  logic                 rel,
`ifdef ARB_LOCK_EN
    input  logic                 lock,
`endif
    output logic [(1<<BITS)-1:0] gnt,
    output logic [BITS-1:0]      gnt_idx,
    output logic                 gnt_vld,
    output logic                 timeout
);

    localparam int N  = 1 << BITS;
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

    if (BITS < 1 || MAX_HOLD < 1) begin : g_bad_param
        $error("Bad parameter value");
    end
    if (BITS > int'(RR_MAX_BITS)) begin : g_bad_bits
        $error("Bad parameter value");
    end

    arb_state_t    state;
    arb_state_t    state_n;
    logic [BITS-1:0] ptr;
    logic [BITS-1:0] ptr_n;
    logic [BITS-1:0] idx_n;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_n;
    logic          vld_n;
    logic [N-1:0]  dec_y;
    logic          lock_on;
    rr_pick_t      pick;
    logic [BITS-1:0] pick_idx;

`ifdef ARB_LOCK_EN
    assign lock_on = lock;
`else
    assign lock_on = 1'b0;
`endif

    assign pick     = rr_pick(RR_MAX_N'(req), 32'(ptr), 32'(N));
    assign pick_idx = BITS'(pick.idx);

    rr_onehot_dec #(
        .BITS (BITS)
    ) u_dec (
        .a (idx_n),
        .y (dec_y)
    );

    // Next-state, hold counter and timeout decision for the IDLE/GRANT/GAP FSM.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        idx_n   = gnt_idx;
        hold_n  = hold_cnt;
        vld_n   = 1'b0;
        timeout = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick.found) begin
                    state_n = GRANT;
                    idx_n   = pick_idx;
                    hold_n  = HW'(1);
                    vld_n   = 1'b1;
                end
            end
            GRANT: begin
                vld_n = 1'b1;
                if (rel) begin
                    state_n = GAP;
                    vld_n   = 1'b0;
                end else if (hold_cnt == HOLD_MAX) begin
                    if (!lock_on) begin
                        state_n = GAP;
                        vld_n   = 1'b0;
                        timeout = 1'b1;
                    end
                end else begin
                    hold_n = hold_cnt + 1'b1;
                end
            end
            GAP: begin
                state_n = IDLE;
                ptr_n   = gnt_idx + 1'b1;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, pointer and registered grant outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            gnt_idx  <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            gnt_vld  <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            gnt_idx  <= idx_n;
            hold_cnt <= hold_n;
            gnt      <= vld_n ? dec_y : '0;
            gnt_vld  <= vld_n;
        end
    end

endmodule
